// File: rtl/ehl_ddr_phy_tx_ser_if.sv
// Write-word handshake between the DDR controller write datapath and the
// PHY transmit serialiser.
interface ehl_ddr_phy_tx_ser_if #(
    parameter int LANES = 2,
    parameter int BEATS = 2
);
    logic                     in_valid;
    logic                     in_ready;
    logic [BEATS*LANES*8-1:0] in_data;
    logic [BEATS*LANES-1:0]   in_mask;
    logic                     in_last;

    modport master (
        output in_valid,
        output in_data,
        output in_mask,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_mask,
        input  in_last,
        output in_ready
    );
endinterface

// File: rtl/ehl_ddr_phy_tx_ser.sv
// DDR write-path transmitter: word FIFO, one beat per clock onto DQ/DM,
// DQS with programmable preamble and a 1-cycle postamble.
module ehl_ddr_phy_tx_ser #(
    parameter int LANES = 2,
    parameter int BEATS = 2,
    parameter int DEPTH = 4
) (
    input  logic                   i_clk_0,
    input  logic                   i_reset,
    ehl_ddr_phy_tx_ser_if.slave    wr,
    input  logic [1:0]             i_pre_cycles,
    output logic [LANES*8-1:0]     o_dq,
    output logic [LANES-1:0]       o_dm,
    output logic [LANES-1:0]       o_dqs,
    output logic [LANES-1:0]       o_dqs_n,
    output logic                   o_dq_oe,
    output logic                   o_dqs_oe,
    output logic                   o_busy,
    output logic                   o_underrun
);
    localparam int AW  = $clog2(DEPTH);
    localparam int BW  = $clog2(BEATS);
    localparam int BDW = LANES * 8;
    localparam int DW  = BEATS * BDW;
    localparam int MW  = BEATS * LANES;
    localparam int EW  = 1 + MW + DW;

    localparam logic [AW:0]      CNT_FULL  = (AW+1)'(DEPTH);
    localparam logic [AW:0]      CNT_ZERO  = {(AW+1){1'b0}};
    localparam logic [AW:0]      CNT_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0]    PTR_ZERO  = {AW{1'b0}};
    localparam logic [AW-1:0]    PTR_ONE   = AW'(1);
    localparam logic [BW-1:0]    BEAT_ZERO = {BW{1'b0}};
    localparam logic [BW-1:0]    BEAT_ONE  = BW'(1);
    localparam logic [BW-1:0]    BEAT_LAST = BW'(BEATS - 1);
    localparam logic [BDW-1:0]   DQ_ZERO   = {BDW{1'b0}};
    localparam logic [LANES-1:0] LANE_ONES = {LANES{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_DATA = 2'd2,
        ST_POST = 2'd3
    } state_t;

    logic [EW-1:0]    r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;

    state_t           r_state;
    logic [1:0]       r_pre_cnt;
    logic [BW-1:0]    r_beat;
    logic             r_word_last;

    logic [BDW-1:0]   r_dq;
    logic [LANES-1:0] r_dm;
    logic             r_dqs;
    logic             r_dq_oe;
    logic             r_dqs_oe;
    logic             r_busy;
    logic             r_underrun;

    logic             w_ready;
    logic             w_push;
    logic             w_pop;
    logic [EW-1:0]    w_entry;
    logic [EW-1:0]    w_head;
    logic             w_head_last;
    logic [BDW-1:0]   w_beat_dq [BEATS];
    logic [LANES-1:0] w_beat_dm [BEATS];

    state_t           w_state_nxt;
    logic [1:0]       w_pre_nxt;
    logic [BW-1:0]    w_beat_nxt;
    logic             w_emit;
    logic             w_set_unr;
    logic [BDW-1:0]   w_dq_nxt;
    logic [LANES-1:0] w_dm_nxt;
    logic             w_dqs_nxt;
    logic             w_dqs_oe_nxt;

    assign w_ready     = (r_count != CNT_FULL);
    assign wr.in_ready = w_ready;
    assign w_push      = wr.in_valid & w_ready;
    assign w_entry     = {wr.in_last, wr.in_mask, wr.in_data};
    assign w_head      = r_mem[r_rptr];
    assign w_head_last = w_head[EW-1];

    for (genvar k = 0; k < BEATS; k++) begin : g_beat
        assign w_beat_dq[k] = w_head[k*BDW +: BDW];
        assign w_beat_dm[k] = w_head[DW + k*LANES +: LANES];
    end

    // FIFO storage; contents need no reset because the pointers and count do
    always_ff @(posedge i_clk_0) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_entry;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge i_clk_0) begin
        if (i_reset) begin
            r_wptr  <= PTR_ZERO;
            r_rptr  <= PTR_ZERO;
            r_count <= CNT_ZERO;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Next-state and next-output decode. r_state names the phase the
    // registered outputs currently show; r_beat is the beat on DQ now.
    always_comb begin
        w_state_nxt  = r_state;
        w_pre_nxt    = r_pre_cnt;
        w_beat_nxt   = r_beat;
        w_emit       = 1'b0;
        w_set_unr    = 1'b0;
        w_dqs_nxt    = 1'b0;
        w_dqs_oe_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_count != CNT_ZERO) begin
                    w_pre_nxt = i_pre_cycles;
                    if (i_pre_cycles != 2'd0) begin
                        w_state_nxt  = ST_PRE;
                        w_dqs_nxt    = ~i_pre_cycles[0];
                        w_dqs_oe_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_DATA;
                        w_emit      = 1'b1;
                        w_beat_nxt  = BEAT_ZERO;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_PRE: begin
                if (r_pre_cnt == 2'd1) begin
                    w_state_nxt = ST_DATA;
                    w_emit      = 1'b1;
                    w_beat_nxt  = BEAT_ZERO;
                end else begin
                    // preamble ends on dqs=0, so dqs tracks the parity of the remaining count
                    w_pre_nxt    = r_pre_cnt - 2'd1;
                    w_dqs_nxt    = r_pre_cnt[0];
                    w_dqs_oe_nxt = 1'b1;
                end
            end
            ST_DATA: begin
                if (r_beat != BEAT_LAST) begin
                    w_emit     = 1'b1;
                    w_beat_nxt = r_beat + BEAT_ONE;
                end else if (r_word_last) begin
                    w_state_nxt  = ST_POST;
                    w_dqs_oe_nxt = 1'b1;
                end else if (r_count != CNT_ZERO) begin
                    w_emit     = 1'b1;
                    w_beat_nxt = BEAT_ZERO;
                end else begin
                    w_state_nxt  = ST_POST;
                    w_dqs_oe_nxt = 1'b1;
                    w_set_unr    = 1'b1;
                end
            end
            ST_POST: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // BEATS is even, so beat parity within a word equals parity within the burst
        if (w_emit) begin
            w_dq_nxt     = w_beat_dq[w_beat_nxt];
            w_dm_nxt     = w_beat_dm[w_beat_nxt];
            w_dqs_nxt    = ~w_beat_nxt[0];
            w_dqs_oe_nxt = 1'b1;
            w_pop        = (w_beat_nxt == BEAT_LAST);
        end else begin
            w_dq_nxt = r_dq;
            w_dm_nxt = LANE_ONES;
            w_pop    = 1'b0;
        end
    end

    // FSM state and registered pad-side outputs
    always_ff @(posedge i_clk_0) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_pre_cnt   <= 2'd0;
            r_beat      <= BEAT_ZERO;
            r_word_last <= 1'b0;
            r_dq        <= DQ_ZERO;
            r_dm        <= LANE_ONES;
            r_dqs       <= 1'b0;
            r_dq_oe     <= 1'b0;
            r_dqs_oe    <= 1'b0;
            r_busy      <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pre_cnt  <= w_pre_nxt;
            r_beat     <= w_beat_nxt;
            r_dq       <= w_dq_nxt;
            r_dm       <= w_dm_nxt;
            r_dqs      <= w_dqs_nxt;
            r_dq_oe    <= w_emit;
            r_dqs_oe   <= w_dqs_oe_nxt;
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_underrun <= r_underrun | w_set_unr;
            if (w_pop) begin
                r_word_last <= w_head_last;
            end
        end
    end

    assign o_dq       = r_dq;
    assign o_dm       = r_dm;
    assign o_dqs      = {LANES{r_dqs}};
    assign o_dqs_n    = {LANES{~r_dqs}};
    assign o_dq_oe    = r_dq_oe;
    assign o_dqs_oe   = r_dqs_oe;
    assign o_busy     = r_busy;
    assign o_underrun = r_underrun;

endmodule

// File: tb/tb_ehl_ddr_phy_tx_ser.sv
// Directed self-checking bench for ehl_ddr_phy_tx_ser (LANES=2, BEATS=2, DEPTH=4).
module tb_ehl_ddr_phy_tx_ser;
    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  pre_cycles;
    logic [15:0] dq;
    logic [1:0]  dm;
    logic [1:0]  dqs;
    logic [1:0]  dqs_n;
    logic        dq_oe;
    logic        dqs_oe;
    logic        busy;
    logic        underrun;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] st_data [8];
    logic [3:0]  st_mask [8];
    logic        st_last [8];

    logic [15:0] cap_dq     [32];
    logic [1:0]  cap_dm     [32];
    logic [1:0]  cap_dqs    [32];
    logic [1:0]  cap_dqs_n  [32];
    logic        cap_dq_oe  [32];
    logic        cap_dqs_oe [32];
    logic        cap_rdy    [32];
    logic        cap_unr    [32];

    ehl_ddr_phy_tx_ser_if #(.LANES(2), .BEATS(2)) wif ();

    ehl_ddr_phy_tx_ser #(.LANES(2), .BEATS(2), .DEPTH(4)) dut (
        .i_clk_0      (clk),
        .i_reset      (reset),
        .wr           (wif.slave),
        .i_pre_cycles (pre_cycles),
        .o_dq         (dq),
        .o_dm         (dm),
        .o_dqs        (dqs),
        .o_dqs_n      (dqs_n),
        .o_dq_oe      (dq_oe),
        .o_dqs_oe     (dqs_oe),
        .o_busy       (busy),
        .o_underrun   (underrun)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers st_* words in order for ncyc edges and records outputs after each edge.
    // Sample c is taken just after edge E+c, where E is the first write edge.
    task automatic stream(input int nw, input int ncyc, input int chg_at, input logic [1:0] chg_val);
        int   idx;
        logic acc;
        idx = 0;
        for (int c = 0; c < ncyc; c++) begin
            if (idx < nw) begin
                wif.in_valid = 1'b1;
                wif.in_data  = st_data[idx];
                wif.in_mask  = st_mask[idx];
                wif.in_last  = st_last[idx];
            end else begin
                wif.in_valid = 1'b0;
            end
            acc = wif.in_valid & wif.in_ready;
            step();
            if (acc) idx++;
            cap_dq[c]     = dq;
            cap_dm[c]     = dm;
            cap_dqs[c]    = dqs;
            cap_dqs_n[c]  = dqs_n;
            cap_dq_oe[c]  = dq_oe;
            cap_dqs_oe[c] = dqs_oe;
            cap_rdy[c]    = wif.in_ready;
            cap_unr[c]    = underrun;
            if (c == chg_at) pre_cycles = chg_val;
        end
        wif.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        pre_cycles   = 2'd0;
        wif.in_valid = 1'b0;
        wif.in_data  = 32'h0;
        wif.in_mask  = 4'h0;
        wif.in_last  = 1'b0;
        step();
        step();
        n_checks++;
        if ({dq, dm, dqs, dqs_n} !== {16'h0000, 2'b11, 2'b00, 2'b11}) begin
            n_fail++;
            $display("FAIL reset_pads: got dq=%h dm=%b dqs=%b dqs_n=%b want 0000 11 00 11", dq, dm, dqs, dqs_n);
        end
        n_checks++;
        if ({dq_oe, dqs_oe, busy, underrun, wif.in_ready} !== 5'b00001) begin
            n_fail++;
            $display("FAIL reset_ctrl: got oe=%b%b busy=%b unr=%b rdy=%b want 00 0 0 1", dq_oe, dqs_oe, busy, underrun, wif.in_ready);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_data();
        pre_cycles   = 2'd0;
        wif.in_valid = 1'b1;
        wif.in_data  = 32'h1234_5678;
        wif.in_mask  = 4'b0000;
        wif.in_last  = 1'b0;
        step();
        wif.in_data  = 32'h9ABC_DEF0;
        wif.in_last  = 1'b1;
        step();
        wif.in_valid = 1'b0;
        n_checks++;
        if ({dq_oe, dq} !== {1'b1, 16'h5678}) begin
            n_fail++;
            $display("FAIL mid_data_setup: got oe=%b dq=%h want 1 5678", dq_oe, dq);
        end
        reset = 1'b1;
        step();
        n_checks++;
        if ({dq, dm, dqs, dqs_n, dq_oe, dqs_oe, busy, underrun, wif.in_ready} !==
            {16'h0000, 2'b11, 2'b00, 2'b11, 5'b00001}) begin
            n_fail++;
            $display("FAIL mid_data_reset: got dq=%h dm=%b dqs=%b dqs_n=%b oe=%b%b busy=%b unr=%b rdy=%b want 0000 11 00 11 00 0 0 1",
                     dq, dm, dqs, dqs_n, dq_oe, dqs_oe, busy, underrun, wif.in_ready);
        end
        reset = 1'b0;
        // the FIFO was emptied, so nothing may start afterwards
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if ({dq_oe, dqs_oe, busy} !== 3'b000) begin
                n_fail++;
                $display("FAIL mid_data_flush[%0d]: got oe=%b%b busy=%b want 000", i, dq_oe, dqs_oe, busy);
            end
        end
    endtask

    task automatic test_single_pre1();
        logic [6:0]  e_dqs, e_dq_oe, e_dqs_oe;
        logic [15:0] e_dq [7];
        logic [1:0]  e_dm [7];
        int n_dq_oe, n_dqs_oe;
        e_dqs    = 7'b0010000;
        e_dq_oe  = 7'b0011000;
        e_dqs_oe = 7'b0111100;
        e_dq[0] = 16'h0000; e_dq[1] = 16'h0000; e_dq[2] = 16'h3C3C; e_dq[3] = 16'hA5A5;
        e_dq[4] = 16'hA5A5; e_dq[5] = 16'hA5A5; e_dq[6] = 16'hA5A5;
        e_dm[0] = 2'b11; e_dm[1] = 2'b11; e_dm[2] = 2'b00; e_dm[3] = 2'b00;
        e_dm[4] = 2'b11; e_dm[5] = 2'b11; e_dm[6] = 2'b11;
        st_data[0] = 32'hA5A5_3C3C; st_mask[0] = 4'b0000; st_last[0] = 1'b1;
        pre_cycles = 2'd1;
        stream(1, 7, -1, 2'd0);
        n_dq_oe  = 0;
        n_dqs_oe = 0;
        for (int i = 0; i < 7; i++) begin
            n_dq_oe  += int'(cap_dq_oe[i]);
            n_dqs_oe += int'(cap_dqs_oe[i]);
            n_checks++;
            if ({cap_dqs[i], cap_dqs_n[i], cap_dq_oe[i], cap_dqs_oe[i], cap_dq[i], cap_dm[i]} !==
                {{2{e_dqs[6-i]}}, {2{~e_dqs[6-i]}}, e_dq_oe[6-i], e_dqs_oe[6-i], e_dq[i], e_dm[i]}) begin
                n_fail++;
                $display("FAIL single_pre1[%0d]: got dqs=%b dqs_n=%b oe=%b%b dq=%h dm=%b want dqs=%b oe=%b%b dq=%h dm=%b",
                         i, cap_dqs[i], cap_dqs_n[i], cap_dq_oe[i], cap_dqs_oe[i], cap_dq[i], cap_dm[i],
                         e_dqs[6-i], e_dq_oe[6-i], e_dqs_oe[6-i], e_dq[i], e_dm[i]);
            end
        end
        n_checks++;
        if ({n_dq_oe, n_dqs_oe} !== {32'd2, 32'd4}) begin
            n_fail++;
            $display("FAIL single_oe_len: got dq_oe=%0d dqs_oe=%0d cycles want 2 4", n_dq_oe, n_dqs_oe);
        end
    endtask

    task automatic test_preamble();
        logic [1:0] plist [3];
        logic [7:0] e_dqs, e_dqs_oe, e_dq_oe;
        int first;
        plist[0] = 2'd0; plist[1] = 2'd2; plist[2] = 2'd3;
        for (int t = 0; t < 3; t++) begin
            case (plist[t])
                2'd0: begin e_dqs = 8'b1000_0000; e_dqs_oe = 8'b1110_0000; e_dq_oe = 8'b1100_0000; end
                2'd2: begin e_dqs = 8'b1010_0000; e_dqs_oe = 8'b1111_1000; e_dq_oe = 8'b0011_0000; end
                default: begin e_dqs = 8'b0101_0000; e_dqs_oe = 8'b1111_1100; e_dq_oe = 8'b0001_1000; end
            endcase
            st_data[0] = 32'h0F0F_F0F0; st_mask[0] = 4'b0000; st_last[0] = 1'b1;
            pre_cycles = plist[t];
            // pre_cycles is disturbed after the burst starts and must have no effect
            stream(1, 9, 1, ~plist[t]);
            for (int i = 0; i < 8; i++) begin
                n_checks++;
                if ({cap_dqs[i+1][0], cap_dqs_oe[i+1], cap_dq_oe[i+1]} !== {e_dqs[7-i], e_dqs_oe[7-i], e_dq_oe[7-i]}) begin
                    n_fail++;
                    $display("FAIL preamble_p%0d[%0d]: got dqs=%b dqs_oe=%b dq_oe=%b want %b %b %b", plist[t], i,
                             cap_dqs[i+1][0], cap_dqs_oe[i+1], cap_dq_oe[i+1], e_dqs[7-i], e_dqs_oe[7-i], e_dq_oe[7-i]);
                end
            end
            first = 1 + int'(plist[t]);
            n_checks++;
            if ({cap_dq[first], cap_dqs[first]} !== {16'hF0F0, 2'b11}) begin
                n_fail++;
                $display("FAIL preamble_first_p%0d: got dq=%h dqs=%b want f0f0 11", plist[t], cap_dq[first], cap_dqs[first]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] e_dq;
        logic [1:0]  e_dm;
        for (int k = 0; k < 4; k++) begin
            st_data[k] = {16'hD001 + 16'(2*k), 16'hD000 + 16'(2*k)};
            st_mask[k] = (k == 1) ? 4'b1001 : 4'b0000;
            st_last[k] = (k == 3);
        end
        pre_cycles = 2'd1;
        stream(4, 14, -1, 2'd0);
        n_checks++;
        if ({cap_dq_oe[1], cap_dqs_oe[1], cap_dqs[1]} !== {1'b0, 1'b1, 2'b00}) begin
            n_fail++;
            $display("FAIL b2b_pre: got dq_oe=%b dqs_oe=%b dqs=%b want 0 1 00", cap_dq_oe[1], cap_dqs_oe[1], cap_dqs[1]);
        end
        for (int j = 0; j < 8; j++) begin
            e_dq = 16'hD000 + 16'(j);
            e_dm = (j == 2) ? 2'b01 : ((j == 3) ? 2'b10 : 2'b00);
            n_checks++;
            if ({cap_dq_oe[j+2], cap_dq[j+2], cap_dm[j+2], cap_dqs[j+2]} !== {1'b1, e_dq, e_dm, {2{(j % 2) == 0}}}) begin
                n_fail++;
                $display("FAIL b2b_beat[%0d]: got oe=%b dq=%h dm=%b dqs=%b want 1 %h %b %b", j,
                         cap_dq_oe[j+2], cap_dq[j+2], cap_dm[j+2], cap_dqs[j+2], e_dq, e_dm, {2{(j % 2) == 0}});
            end
        end
        n_checks++;
        if ({cap_dq_oe[10], cap_dqs_oe[10], cap_dqs[10], cap_unr[12]} !== {1'b0, 1'b1, 2'b00, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_post: got dq_oe=%b dqs_oe=%b dqs=%b unr=%b want 0 1 00 0",
                     cap_dq_oe[10], cap_dqs_oe[10], cap_dqs[10], cap_unr[12]);
        end
    endtask

    task automatic test_fifo_full();
        logic [15:0] e_dq;
        for (int k = 0; k < 5; k++) begin
            st_data[k] = {16'hE001 + 16'(2*k), 16'hE000 + 16'(2*k)};
            st_mask[k] = 4'b0000;
            st_last[k] = (k == 4);
        end
        pre_cycles = 2'd3;
        stream(5, 18, -1, 2'd3);
        // count reaches 4 after the fourth write and stays there until the first pop
        n_checks++;
        if ({cap_rdy[2], cap_rdy[3], cap_rdy[4], cap_rdy[5]} !== 4'b1001) begin
            n_fail++;
            $display("FAIL full_ready: got s2..s5=%b%b%b%b want 1001", cap_rdy[2], cap_rdy[3], cap_rdy[4], cap_rdy[5]);
        end
        for (int j = 0; j < 10; j++) begin
            e_dq = 16'hE000 + 16'(j);
            n_checks++;
            if ({cap_dq_oe[j+4], cap_dq[j+4], cap_dqs[j+4]} !== {1'b1, e_dq, {2{(j % 2) == 0}}}) begin
                n_fail++;
                $display("FAIL full_order[%0d]: got oe=%b dq=%h dqs=%b want 1 %h %b", j,
                         cap_dq_oe[j+4], cap_dq[j+4], cap_dqs[j+4], e_dq, {2{(j % 2) == 0}});
            end
        end
        n_checks++;
        if ({cap_dq_oe[14], cap_dqs_oe[14], cap_dqs_oe[15], cap_unr[16]} !== 4'b0100) begin
            n_fail++;
            $display("FAIL full_post: got dq_oe=%b dqs_oe=%b%b unr=%b want 0 10 0",
                     cap_dq_oe[14], cap_dqs_oe[14], cap_dqs_oe[15], cap_unr[16]);
        end
    endtask

    task automatic test_underrun();
        st_data[0] = 32'h7E7E_8181; st_mask[0] = 4'b0000; st_last[0] = 1'b0;
        pre_cycles = 2'd0;
        stream(1, 6, -1, 2'd0);
        n_checks++;
        if ({cap_dq[1], cap_dq[2], cap_dq_oe[1], cap_dq_oe[2], cap_dq_oe[3]} !== {16'h8181, 16'h7E7E, 3'b110}) begin
            n_fail++;
            $display("FAIL underrun_beats: got dq=%h,%h dq_oe=%b%b%b want 8181,7e7e 110",
                     cap_dq[1], cap_dq[2], cap_dq_oe[1], cap_dq_oe[2], cap_dq_oe[3]);
        end
        n_checks++;
        if ({cap_dqs_oe[3], cap_dqs[3], cap_dq[3], cap_dqs_oe[4]} !== {1'b1, 2'b00, 16'h7E7E, 1'b0}) begin
            n_fail++;
            $display("FAIL underrun_post: got dqs_oe=%b dqs=%b dq=%h next_dqs_oe=%b want 1 00 7e7e 0",
                     cap_dqs_oe[3], cap_dqs[3], cap_dq[3], cap_dqs_oe[4]);
        end
        n_checks++;
        if ({cap_unr[2], cap_unr[3], cap_unr[5]} !== 3'b011) begin
            n_fail++;
            $display("FAIL underrun_flag: got s2,s3,s5=%b%b%b want 011", cap_unr[2], cap_unr[3], cap_unr[5]);
        end
        st_last[0] = 1'b1;
        stream(1, 6, -1, 2'd0);
        n_checks++;
        if ({cap_unr[0], cap_unr[5], cap_dq_oe[1]} !== 3'b111) begin
            n_fail++;
            $display("FAIL underrun_sticky: got unr=%b%b dq_oe=%b want 11 1", cap_unr[0], cap_unr[5], cap_dq_oe[1]);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_checks++;
        if (underrun !== 1'b0) begin
            n_fail++;
            $display("FAIL underrun_clear: got %b want 0", underrun);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_reset_mid_data();
        test_single_pre1();
        test_preamble();
        test_back_to_back();
        test_fifo_full();
        test_underrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
